// File: rtl/tone_pkg.sv
// Shared note table, note codes and detector state encoding for the melody tone
// generator and the tone note detector.
package tone_pkg;

   localparam int PERIOD_W  = 21;
   localparam int NUM_NOTES = 6;

   typedef logic [PERIOD_W-1:0] period_t;
   typedef logic [2:0]          note_t;

   localparam note_t NOTE_FA    = 3'd0;
   localparam note_t NOTE_LA    = 3'd1;
   localparam note_t NOTE_LA_LO = 3'd2;
   localparam note_t NOTE_FA_LO = 3'd3;
   localparam note_t NOTE_MI    = 3'd4;
   localparam note_t NOTE_FA1   = 3'd5;

   localparam period_t PERIOD_FA    = 21'd1086957;
   localparam period_t PERIOD_LA    = 21'd909091;
   localparam period_t PERIOD_LA_LO = 21'd854701;
   localparam period_t PERIOD_FA_LO = 21'd1075269;
   localparam period_t PERIOD_MI    = 21'd1204819;
   localparam period_t PERIOD_FA1   = 21'd1149425;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   // Cycles a new synchronized level must persist before the glitch filter accepts it
   localparam int GLITCH_HOLD = 4;

   function automatic period_t note_period(input note_t code);
      case (code)
         NOTE_FA:    note_period = PERIOD_FA;
         NOTE_LA:    note_period = PERIOD_LA;
         NOTE_LA_LO: note_period = PERIOD_LA_LO;
         NOTE_FA_LO: note_period = PERIOD_FA_LO;
         NOTE_MI:    note_period = PERIOD_MI;
         default:    note_period = PERIOD_FA1;
      endcase
   endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer, optional glitch filter (TONE_DET_GLITCH_FILTER_EN) and a
// registered one-cycle rising-edge pulse.
module tone_edge_sync
   import tone_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic tone_i,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;
   logic prev_q;
   logic rise_q;
   logic lvl;

`ifdef TONE_DET_GLITCH_FILTER_EN
   logic [1:0] run_q;
   logic [1:0] run_d;
   logic       filt_q;
   logic       filt_d;

   // run_q counts consecutive cycles the synchronized level disagrees with filt_q
   always_comb begin
      run_d  = 2'd0;
      filt_d = filt_q;
      if (s2_q != filt_q) begin
         if (run_q == 2'(GLITCH_HOLD - 1)) begin
            filt_d = s2_q;
         end else begin
            run_d = run_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         run_q  <= 2'd0;
         filt_q <= 1'b0;
      end else begin
         run_q  <= run_d;
         filt_q <= filt_d;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = s2_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= tone_i;
         s2_q   <= s1_q;
         prev_q <= lvl;
         rise_q <= lvl & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/tone_note_detector.sv
// Measures the rising-edge period of tone_in, classifies it against the note table and
// reports a debounced lock. Glitch filter option: TONE_DET_GLITCH_FILTER_EN.
module tone_note_detector
   import tone_pkg::*;
#(
   parameter int TOL_SHIFT      = 8,
   parameter int CONFIRM        = 2,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int PERIOD_SHIFT   = 0   // table periods divided by 2^PERIOD_SHIFT; 0 = real table
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                tone_in,
   output logic [2:0]          note_code,
   output logic                note_valid,
   output logic                note_strobe,
   output logic [PERIOD_W-1:0] period
);

   logic       rise;
   logic [1:0] state_q,  state_d;
   period_t    cnt_q,    cnt_d;
   logic [2:0] match_q,  match_d;
   note_t      cand_q,   cand_d;
   note_t      code_q,   code_d;
   logic       valid_q,  valid_d;
   logic       strobe_q, strobe_d;
   period_t    period_q, period_d;

   period_t             meas;
   logic                hit;
   note_t               hit_code;
   logic [PERIOD_W:0]   p_ext, t_ext, diff, tol;
   logic                tmo;

   tone_edge_sync u_sync (
      .clk_i  (clock),
      .rst_i  (reset),
      .tone_i (tone_in),
      .rise_o (rise)
   );

   // Saturate so a very long gap never wraps to a small, matchable period
   assign meas = (cnt_q == '1) ? cnt_q : cnt_q + period_t'(1);
   assign tmo  = (cnt_q == period_t'(TIMEOUT_CYCLES - 1));

   // Scan high to low so the lowest matching code is the one left standing
   always_comb begin
      hit      = 1'b0;
      hit_code = NOTE_FA;
      p_ext    = {1'b0, meas};
      t_ext    = '0;
      diff     = '0;
      tol      = '0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         t_ext = {1'b0, note_period(note_t'(i))} >> PERIOD_SHIFT;
         diff  = (p_ext >= t_ext) ? (p_ext - t_ext) : (t_ext - p_ext);
         tol   = t_ext >> TOL_SHIFT;
         if (diff <= tol) begin
            hit      = 1'b1;
            hit_code = note_t'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      cand_d   = cand_q;
      code_d   = code_q;
      valid_d  = valid_q;
      strobe_d = 1'b0;
      period_d = period_q;
      cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + period_t'(1);

      if (rise) begin
         cnt_d    = '0;
         period_d = meas;
         case (state_q)
            ST_IDLE: begin
               state_d = ST_MEASURE;
               match_d = 3'd0;
            end
            ST_MEASURE: begin
               if (hit) begin
                  if ((hit_code == cand_q) && (match_q != 3'd0)) begin
                     match_d = match_q + 3'd1;
                  end else begin
                     cand_d  = hit_code;
                     match_d = 3'd1;
                  end
               end else begin
                  match_d = 3'd0;
               end
               if (match_d == 3'(CONFIRM)) begin
                  state_d  = ST_LOCKED;
                  code_d   = cand_d;
                  valid_d  = 1'b1;
                  strobe_d = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!(hit && (hit_code == code_q))) begin
                  valid_d = 1'b0;
                  state_d = ST_MEASURE;
                  if (hit) begin
                     cand_d  = hit_code;
                     match_d = 3'd1;
                  end else begin
                     match_d = 3'd0;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               match_d = 3'd0;
            end
         endcase
      end else if (tmo) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         match_d = 3'd0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         match_q  <= 3'd0;
         cand_q   <= NOTE_FA;
         code_q   <= NOTE_FA;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
         period_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         match_q  <= match_d;
         cand_q   <= cand_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         strobe_q <= strobe_d;
         period_q <= period_d;
      end
   end

   assign note_code   = code_q;
   assign note_valid  = valid_q;
   assign note_strobe = strobe_q;
   assign period      = period_q;

endmodule

// File: tb/tb_tone_note_detector.sv
// Directed table-driven bench for tone_note_detector using a scaled-down note table.
module tb_tone_note_detector;
   import tone_pkg::*;

   // Table scaled by 2^10: FA 1061, LA 887, La 834, Fa 1050, MI 1176, FA1 1122
   localparam int PSH = 10;
   localparam int TMO = 1500;
`ifdef TONE_DET_GLITCH_FILTER_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 4;
`endif

   logic                clock   = 1'b0;
   logic                reset   = 1'b1;
   logic                tone_in = 1'b0;
   logic [2:0]          note_code;
   logic                note_valid;
   logic                note_strobe;
   logic [PERIOD_W-1:0] period;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int per;
      bit rst;
      bit gl;
      bit s;
      bit v;
      int c;
      int p;
   } vec_t;

   vec_t vecs[$];

   tone_note_detector #(
      .TOL_SHIFT      (8),
      .CONFIRM        (2),
      .TIMEOUT_CYCLES (TMO),
      .PERIOD_SHIFT   (PSH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .tone_in     (tone_in),
      .note_code   (note_code),
      .note_valid  (note_valid),
      .note_strobe (note_strobe),
      .period      (period)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int per, input bit rst, input bit gl, input bit s,
                               input bit v, input int c, input int p);
      vec_t r;
      r.per = per; r.rst = rst; r.gl = gl; r.s = s; r.v = v; r.c = c; r.p = p;
      return r;
   endfunction

   // One tone period starting with a rising edge; outputs checked LAT cycles after the edge
   task automatic apply_vec(input int idx, input vec_t vv);
      int h;
      int l;
      h = vv.per / 2;
      l = vv.per - h;
      if (vv.rst) begin
         reset   = 1'b1;
         tone_in = 1'b0;
         cycles(2);
         reset = 1'b0;
         cycles(10);
      end
      tone_in = 1'b1;
      cycles(LAT);
      check($sformatf("v%0d.strobe", idx), int'(note_strobe), int'(vv.s));
      check($sformatf("v%0d.valid", idx), int'(note_valid), int'(vv.v));
      check($sformatf("v%0d.code", idx), int'(note_code), vv.c);
      if (vv.p >= 0) check($sformatf("v%0d.period", idx), int'(period), vv.p);
      cycles(1);
      if (vv.s) check($sformatf("v%0d.strobe_end", idx), int'(note_strobe), 0);
      cycles(h - LAT - 1);
      tone_in = 1'b0;
      if (vv.gl) begin
         cycles(l / 2);
         tone_in = 1'b1;
         cycles(2);
         tone_in = 1'b0;
         cycles(l - l / 2 - 2);
      end else begin
         cycles(l);
      end
   endtask

   initial begin
      cycles(3);
      check("rst.code", int'(note_code), 0);
      check("rst.valid", int'(note_valid), 0);
      check("rst.strobe", int'(note_strobe), 0);
      check("rst.period", int'(period), 0);
      check("rst.state", int'(dut.state_q), int'(ST_IDLE));
      check("rst.cnt", int'(dut.cnt_q), 0);
      reset = 1'b0;
      cycles(5);

      // LA lock on 3rd edge
      vecs.push_back(mk(887, 1, 0, 0, 0, 0, -1));
      vecs.push_back(mk(887, 0, 0, 0, 0, 0, 887));
      vecs.push_back(mk(887, 0, 0, 1, 1, 1, 887));
      vecs.push_back(mk(887, 0, 0, 0, 1, 1, 887));
      // Fa
      vecs.push_back(mk(1050, 1, 0, 0, 0, 0, -1));
      vecs.push_back(mk(1050, 0, 0, 0, 0, 0, 1050));
      vecs.push_back(mk(1050, 0, 0, 1, 1, 3, 1050));
      // FA
      vecs.push_back(mk(1061, 1, 0, 0, 0, 0, -1));
      vecs.push_back(mk(1061, 0, 0, 0, 0, 0, 1061));
      vecs.push_back(mk(1061, 0, 0, 1, 1, 0, 1061));
      vecs.push_back(mk(1061, 0, 0, 0, 1, 0, 1061));
      // Between Fa and FA: never locks
      vecs.push_back(mk(1055, 1, 0, 0, 0, 0, -1));
      vecs.push_back(mk(1055, 0, 0, 0, 0, 0, 1055));
      vecs.push_back(mk(1055, 0, 0, 0, 0, 0, 1055));
      vecs.push_back(mk(1055, 0, 0, 0, 0, 0, 1055));
      // La lock, then switch to MI
      vecs.push_back(mk(834, 1, 0, 0, 0, 0, -1));
      vecs.push_back(mk(834, 0, 0, 0, 0, 0, 834));
      vecs.push_back(mk(834, 0, 0, 1, 1, 2, 834));
      vecs.push_back(mk(1176, 0, 0, 0, 1, 2, 834));
      vecs.push_back(mk(1176, 0, 0, 0, 0, 2, 1176));
      vecs.push_back(mk(1176, 0, 0, 1, 1, 4, 1176));
      vecs.push_back(mk(1176, 0, 0, 0, 1, 4, 1176));
      // Tolerance edge for LA (887 +/- 3): 890 hits, 891 misses
      vecs.push_back(mk(890, 1, 0, 0, 0, 0, -1));
      vecs.push_back(mk(890, 0, 0, 0, 0, 0, 890));
      vecs.push_back(mk(891, 0, 0, 1, 1, 1, 890));
      vecs.push_back(mk(887, 0, 0, 0, 0, 1, 891));
      vecs.push_back(mk(887, 0, 0, 0, 0, 1, 887));
      vecs.push_back(mk(887, 0, 0, 1, 1, 1, 887));
      // FA1 with 2-cycle glitches mid low phase (glitch at +841, so 281 remains)
      vecs.push_back(mk(1122, 1, 1, 0, 0, 0, -1));
`ifdef TONE_DET_GLITCH_FILTER_EN
      vecs.push_back(mk(1122, 0, 1, 0, 0, 0, 1122));
      vecs.push_back(mk(1122, 0, 1, 1, 1, 5, 1122));
      vecs.push_back(mk(1122, 0, 1, 0, 1, 5, 1122));
`else
      vecs.push_back(mk(1122, 0, 1, 0, 0, 0, 281));
      vecs.push_back(mk(1122, 0, 1, 0, 0, 0, 281));
      vecs.push_back(mk(1122, 0, 1, 0, 0, 0, 281));
`endif

      for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

      // Lock on FA then go silent until timeout
      apply_vec(100, mk(1061, 1, 0, 0, 0, 0, -1));
      apply_vec(101, mk(1061, 0, 0, 0, 0, 0, 1061));
      apply_vec(102, mk(1061, 0, 0, 1, 1, 0, 1061));
      cycles(300);
      check("tmo.valid_before", int'(note_valid), 1);
      cycles(300);
      check("tmo.valid", int'(note_valid), 0);
      check("tmo.state", int'(dut.state_q), int'(ST_IDLE));
      check("tmo.period", int'(period), 1061);
      check("tmo.code", int'(note_code), 0);
      check("tmo.match", int'(dut.match_q), 0);

      // Asynchronous reset mid-period while locked on LA, then relock
      apply_vec(110, mk(887, 1, 0, 0, 0, 0, -1));
      apply_vec(111, mk(887, 0, 0, 0, 0, 0, 887));
      apply_vec(112, mk(887, 0, 0, 1, 1, 1, 887));
      tone_in = 1'b1;
      cycles(100);
      reset = 1'b1;
      #1;
      check("arst.valid", int'(note_valid), 0);
      check("arst.code", int'(note_code), 0);
      check("arst.period", int'(period), 0);
      check("arst.state", int'(dut.state_q), int'(ST_IDLE));
      check("arst.cnt", int'(dut.cnt_q), 0);
      tone_in = 1'b0;
      cycles(2);
      reset = 1'b0;
      cycles(10);
      apply_vec(113, mk(887, 0, 0, 0, 0, 0, -1));
      apply_vec(114, mk(887, 0, 0, 0, 0, 0, 887));
      apply_vec(115, mk(887, 0, 0, 1, 1, 1, 887));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
